// File: rtl/usb_pkg.sv
// Shared sizing constants for the USB endpoint data path.
package usb_pkg;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int OCC_W  = ADDR_W + 1;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/buffer_ptr.sv
// Wrapping FIFO pointer: index bits plus one wrap bit, synchronous clear, increment enable.
module buffer_ptr
    import usb_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             inc,
    output logic [OCC_W-1:0] ptr
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + OCC_W'(1);
        end
    end

endmodule

// File: rtl/data_buffer.sv
// 64-byte shared first-word-fall-through endpoint buffer between the AHB slave and the USB RX/TX cores.
// Strobes are single-cycle requests with no ready: a write is taken if not full, a pop if not empty, otherwise the matching error pulse fires.
module data_buffer
    import usb_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              store_tx_data,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              store_rx_packet_data,
    input  logic [BYTE_W-1:0] rx_packet_data,
    input  logic              get_rx_data,
    output logic [BYTE_W-1:0] rx_data,
    input  logic              get_tx_packet_data,
    output logic [BYTE_W-1:0] tx_packet_data,
    output logic [OCC_W-1:0]  buffer_occupancy,
    output logic              overflow,
    output logic              underflow
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [OCC_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  rd_ptr;
    logic              full;
    logic              empty;
    logic              wr_req;
    logic              rd_req;
    logic              wr_en;
    logic              rd_en;
    logic [BYTE_W-1:0] wr_byte;
    logic [BYTE_W-1:0] head;
    logic              overflow_next;
    logic              underflow_next;

    buffer_ptr u_wr_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    buffer_ptr u_rd_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .inc   (rd_en),
        .ptr   (rd_ptr)
    );

    // Wrap bit makes the modulo-128 difference span the full 0..64 range.
    assign buffer_occupancy = wr_ptr - rd_ptr;
    assign full  = (buffer_occupancy == OCC_W'(DEPTH));
    assign empty = (buffer_occupancy == '0);

    always_comb begin
        wr_req  = store_tx_data | store_rx_packet_data;
        rd_req  = get_rx_data | get_tx_packet_data;
        wr_byte = store_tx_data ? tx_data : rx_packet_data;
        wr_en   = wr_req & ~full & ~clear;
        rd_en   = rd_req & ~empty & ~clear;
        // Colliding write strobes lose the RX byte, reported like a full-buffer drop.
        overflow_next  = ~clear & ((wr_req & full) | (store_tx_data & store_rx_packet_data));
        underflow_next = ~clear & rd_req & empty;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_byte;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

    assign head           = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
    assign rx_data        = head;
    assign tx_packet_data = head;

endmodule

// File: tb/tb_data_buffer.sv
// Directed bench for data_buffer: queue reference model checked every cycle plus literal expectations.
module tb_data_buffer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic       get_rx_data;
    logic [7:0] rx_data;
    logic       get_tx_packet_data;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic       exp_unf = 1'b0;

    data_buffer dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy),
        .overflow             (overflow),
        .underflow            (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a byte queue updated from the strobes seen at each rising edge.
    always @(posedge clk) begin
        logic wr_req;
        logic rd_req;
        int   occ;
        if (!n_rst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else if (clear) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            wr_req  = store_tx_data || store_rx_packet_data;
            rd_req  = get_rx_data || get_tx_packet_data;
            occ     = exp_q.size();
            exp_ovf = (wr_req && occ == 64) || (store_tx_data && store_rx_packet_data);
            exp_unf = rd_req && occ == 0;
            if (rd_req && occ > 0) void'(exp_q.pop_front());
            if (wr_req && occ < 64) exp_q.push_back(store_tx_data ? tx_data : rx_packet_data);
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_head;
        if (n_rst) begin
            exp_head = (exp_q.size() == 0) ? 8'h00 : exp_q[0];
            chk("model_occupancy", int'(buffer_occupancy), exp_q.size());
            chk("model_rx_data", int'(rx_data), int'(exp_head));
            chk("model_tx_packet_data", int'(tx_packet_data), int'(exp_head));
            chk("model_overflow", int'(overflow), int'(exp_ovf));
            chk("model_underflow", int'(underflow), int'(exp_unf));
        end
    end

    task automatic idle_inputs();
        clear = 0; store_tx_data = 0; tx_data = 0; store_rx_packet_data = 0;
        rx_packet_data = 0; get_rx_data = 0; get_tx_packet_data = 0;
    endtask

    // Apply one cycle of strobes; returns 1 time unit after the edge with inputs idle.
    task automatic drive(input logic stx, input logic [7:0] txd, input logic srx,
                         input logic [7:0] rxd, input logic grx, input logic gtx,
                         input logic clr);
        store_tx_data = stx; tx_data = txd; store_rx_packet_data = srx;
        rx_packet_data = rxd; get_rx_data = grx; get_tx_packet_data = gtx; clear = clr;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic write_byte(input logic [7:0] b);
        drive(1, b, 0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        n_rst = 1'b0;
        idle_inputs();
        #1;
        chk("reset_occupancy", int'(buffer_occupancy), 0);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_tx_packet_data", int'(tx_packet_data), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_underflow", int'(underflow), 0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Four writes then four pops through the TX side.
        for (int i = 0; i < 4; i++) write_byte(8'hA1 + 8'(i));
        chk("four_occupancy", int'(buffer_occupancy), 4);
        for (int i = 0; i < 4; i++) begin
            chk("four_head", int'(tx_packet_data), 'hA1 + i);
            drive(0, 8'h00, 0, 8'h00, 0, 1, 0);
            chk("four_pop_occupancy", int'(buffer_occupancy), 3 - i);
        end

        // Fill to full, overflow on the 65th write, drain in order.
        for (int i = 0; i < 64; i++) write_byte(8'(i));
        chk("full_occupancy", int'(buffer_occupancy), 64);
        write_byte(8'hFF);
        chk("full_write_occupancy", int'(buffer_occupancy), 64);
        chk("full_write_overflow", int'(overflow), 1);
        drive(0, 8'h00, 0, 8'h00, 0, 0, 0);
        chk("overflow_not_sticky", int'(overflow), 0);
        for (int i = 0; i < 64; i++) begin
            chk("drain_head", int'(rx_data), i);
            drive(0, 8'h00, 0, 8'h00, 1, 0, 0);
        end
        chk("drain_occupancy", int'(buffer_occupancy), 0);

        // Pop on empty.
        chk("empty_rx_data", int'(rx_data), 0);
        drive(0, 8'h00, 0, 8'h00, 1, 0, 0);
        chk("empty_underflow", int'(underflow), 1);
        chk("empty_occupancy", int'(buffer_occupancy), 0);

        // Empty with write and read together: write lands, underflow pulses.
        drive(1, 8'h3C, 0, 8'h00, 1, 0, 0);
        chk("empty_wr_rd_underflow", int'(underflow), 1);
        chk("empty_wr_rd_occupancy", int'(buffer_occupancy), 1);
        chk("empty_wr_rd_head", int'(rx_data), 'h3C);
        drive(0, 8'h00, 0, 8'h00, 0, 1, 0);

        // Concurrent write/read at occupancy 10, then colliding write strobes.
        for (int i = 0; i < 10; i++) write_byte(8'h80 + 8'(i));
        for (int i = 0; i < 5; i++) drive(0, 8'h00, 1, 8'h5A, 1, 0, 0);
        chk("steady_occupancy", int'(buffer_occupancy), 10);
        chk("steady_head", int'(rx_data), 'h85);
        drive(1, 8'h77, 1, 8'h33, 0, 0, 0);
        chk("collide_overflow", int'(overflow), 1);
        chk("collide_occupancy", int'(buffer_occupancy), 11);
        for (int i = 0; i < 10; i++) drive(0, 8'h00, 0, 8'h00, 1, 1, 0);
        chk("collide_stored_tx", int'(rx_data), 'h77);
        drive(0, 8'h00, 0, 8'h00, 1, 1, 0);
        chk("dual_pop_occupancy", int'(buffer_occupancy), 0);

        // Clear beats a concurrent write.
        for (int i = 0; i < 20; i++) write_byte(8'h40 + 8'(i));
        drive(1, 8'h11, 0, 8'h00, 0, 0, 1);
        chk("clear_occupancy", int'(buffer_occupancy), 0);
        chk("clear_rx_data", int'(rx_data), 0);
        chk("clear_overflow", int'(overflow), 0);
        chk("clear_underflow", int'(underflow), 0);
        write_byte(8'h22);
        chk("after_clear_head", int'(rx_data), 'h22);

        // Full with write and read: read taken, write dropped.
        for (int i = 0; i < 63; i++) write_byte(8'hC0 + 8'(i));
        drive(1, 8'hEE, 0, 8'h00, 1, 0, 0);
        chk("full_wr_rd_occupancy", int'(buffer_occupancy), 63);
        chk("full_wr_rd_overflow", int'(overflow), 1);
        chk("full_wr_rd_head", int'(rx_data), 'hC0);
        drive(0, 8'h00, 0, 8'h00, 1, 0, 1);
        drive(1, 8'h99, 0, 8'h00, 1, 0, 1);
        chk("held_clear_occupancy", int'(buffer_occupancy), 0);
        chk("held_clear_underflow", int'(underflow), 0);

        // 200-byte stream with the read trailing by two cycles, wrapping the pointers.
        for (int t = 0; t < 202; t++) begin
            if (t >= 2) chk("stream_head", int'(tx_packet_data), (t - 2) & 'hFF);
            drive(t < 200, 8'(t), 0, 8'h00, 0, t >= 2, 0);
            chk("stream_occupancy_bound", int'(buffer_occupancy <= 7'd3), 1);
        end
        chk("stream_end_occupancy", int'(buffer_occupancy), 0);

        // Reset in the middle of a packet takes effect without waiting for a clock.
        for (int i = 0; i < 3; i++) write_byte(8'hD0 + 8'(i));
        #2;
        n_rst = 1'b0;
        #1;
        chk("midreset_occupancy", int'(buffer_occupancy), 0);
        chk("midreset_rx_data", int'(rx_data), 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        write_byte(8'h5E);
        chk("post_reset_head", int'(tx_packet_data), 'h5E);
        chk("post_reset_occupancy", int'(buffer_occupancy), 1);
        drive(0, 8'h00, 0, 8'h00, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
